lcd_nibble_writer: RTL

Byte-level HD44780 4-bit bus driver. Accepts one command or character byte per valid/ready handshake and drives the LCD pins (`lcd_rs`, `lcd_rw`, `lcd_e`, `lcd_4..lcd_7`) as two nibble strobes with controller-safe setup, pulse and execution delays. After reset it runs the power-on 4-bit initialisation nibble sequence on its own. It sits between the two-line text sequencer, which holds the 32-character screen image, and the LCD pins. The sequencer only issues bytes; all pin timing lives here.

---
 rtl/lcd_nibble_writer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/lcd_nibble_writer.sv
// HD44780 4-bit bus driver: runs the power-on init nibbles, then writes one byte per handshake as two E strobes.
// Latency: pins driven on the handshake edge; in_ready returns 2*(T_AS+T_EH)+T_NIB+exec wait cycles later.
// Backpressure: in_ready is high only in IDLE; in_valid while busy is ignored and inputs are latched at handshake.
module lcd_nibble_writer #(
  parameter int unsigned T_AS    = 2,
  parameter int unsigned T_EH    = 12,
  parameter int unsigned T_NIB   = 50,
  parameter int unsigned T_CMD   = 2000,
  parameter int unsigned T_LONG  = 82000,
  parameter int unsigned T_PWR   = 750000,
  parameter int unsigned T_INIT1 = 205000,
  parameter int unsigned T_INIT2 = 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic       lcd_4,
  output logic       lcd_5,
  output logic       lcd_6,
  output logic       lcd_7
);

  // Counter sized for the longest delay, never narrower than 20 bits.
  localparam int unsigned M_A    = (T_PWR > T_INIT1) ? T_PWR : T_INIT1;
  localparam int unsigned M_B    = (T_LONG > T_INIT2) ? T_LONG : T_INIT2;
  localparam int unsigned M_C    = (T_CMD > T_NIB) ? T_CMD : T_NIB;
  localparam int unsigned M_D    = (T_AS > T_EH) ? T_AS : T_EH;
  localparam int unsigned M_AB   = (M_A > M_B) ? M_A : M_B;
  localparam int unsigned M_CD   = (M_C > M_D) ? M_C : M_D;
  localparam int unsigned MAX_T  = (M_AB > M_CD) ? M_AB : M_CD;
  localparam int unsigned CW_RAW = $clog2(MAX_T + 1);
  localparam int unsigned CW     = (CW_RAW > 20) ? CW_RAW : 20;

  typedef enum logic [2:0] {
    PWR_WAIT  = 3'd0,
    SETUP     = 3'd1,
    E_HIGH    = 3'd2,
    GAP       = 3'd3,
    EXEC_WAIT = 3'd4,
    IDLE      = 3'd5
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [CW-1:0]   dur;
  logic            tick;
  logic [1:0]      idx, idx_n;       // init nibble number, or byte half (0 = high)
  logic [3:0]      lo_nib, lo_nib_n; // low nibble kept for the second strobe
  logic            long_wait, long_wait_n;
  logic            e_q, e_n;
  logic            rs_q, rs_n;
  logic [3:0]      nib_q, nib_n;
  logic            done_q, done_n;

  // Length of the current state in cycles; tick marks its last cycle.
  always_comb begin
    dur = CW'(1);
    case (state)
      PWR_WAIT:  dur = CW'(T_PWR);
      SETUP:     dur = CW'(T_AS);
      E_HIGH:    dur = CW'(T_EH);
      GAP:       dur = CW'(T_NIB);
      EXEC_WAIT: begin
        if (!done_q) dur = (idx == 2'd0) ? CW'(T_INIT1) : CW'(T_INIT2);
        else         dur = long_wait ? CW'(T_LONG) : CW'(T_CMD);
      end
      default:   dur = CW'(1);
    endcase
  end

  assign tick = (cnt == dur - CW'(1));

  // Next-state and next pin values; pins only change on entry to SETUP so they are stable around E.
  always_comb begin
    state_n     = state;
    cnt_n       = tick ? '0 : cnt + CW'(1);
    idx_n       = idx;
    lo_nib_n    = lo_nib;
    long_wait_n = long_wait;
    e_n         = e_q;
    rs_n        = rs_q;
    nib_n       = nib_q;
    done_n      = done_q;
    case (state)
      PWR_WAIT: begin
        if (tick) begin
          state_n = SETUP;
          rs_n    = 1'b0;
          nib_n   = 4'h3;
          idx_n   = 2'd0;
        end
      end
      SETUP: begin
        if (tick) begin
          state_n = E_HIGH;
          e_n     = 1'b1;
        end
      end
      E_HIGH: begin
        if (tick) begin
          e_n     = 1'b0;
          state_n = (done_q && idx == 2'd0) ? GAP : EXEC_WAIT;
        end
      end
      GAP: begin
        if (tick) begin
          state_n = SETUP;
          nib_n   = lo_nib;
          idx_n   = 2'd1;
        end
      end
      EXEC_WAIT: begin
        if (tick) begin
          if (done_q) begin
            state_n = IDLE;
          end else if (idx == 2'd3) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = SETUP;
            idx_n   = idx + 2'd1;
            nib_n   = (idx == 2'd2) ? 4'h2 : 4'h3;
          end
        end
      end
      IDLE: begin
        cnt_n = '0;
        if (in_valid) begin
          state_n     = SETUP;
          rs_n        = in_rs;
          nib_n       = in_data[7:4];
          lo_nib_n    = in_data[3:0];
          idx_n       = 2'd0;
          // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
          long_wait_n = !in_rs && (in_data[7:2] == 6'd0) && (in_data[1:0] != 2'd0);
        end
      end
      default: begin
        state_n = PWR_WAIT;
        cnt_n   = '0;
      end
    endcase
  end

  // State and pin registers; reset clears everything and restarts the init sequence.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= PWR_WAIT;
      cnt       <= '0;
      idx       <= 2'd0;
      lo_nib    <= 4'h0;
      long_wait <= 1'b0;
      e_q       <= 1'b0;
      rs_q      <= 1'b0;
      nib_q     <= 4'h0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      lo_nib    <= lo_nib_n;
      long_wait <= long_wait_n;
      e_q       <= e_n;
      rs_q      <= rs_n;
      nib_q     <= nib_n;
      done_q    <= done_n;
    end
  end

  assign in_ready  = (state == IDLE);
  assign init_done = done_q;
  assign lcd_rs    = rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_e     = e_q;
  assign lcd_4     = nib_q[0];
  assign lcd_5     = nib_q[1];
  assign lcd_6     = nib_q[2];
  assign lcd_7     = nib_q[3];

endmodule
